fir_stream_filter: RTL

//  Parametrised streaming FIR filter for the radar receive chain: TAPS-tap signed

---
 rtl/fir_stream_filter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fir_stream_filter.sv
// Streaming TAPS-tap signed FIR with runtime coefficients, round-half-up scaling and valid/ready flow control.
// Build option: define FIR_SAT_EN to clip the result and drive out_sat; otherwise the result wraps and out_sat stays 0.
module fir_stream_filter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 5,
  parameter int unsigned TAPS   = 5,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned SHIFT  = 2,
  parameter logic [TAPS*COEF_W-1:0] COEF_INIT = {TAPS{5'sd4}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sat
);

  localparam int unsigned AW     = $clog2(TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);
  // One guard bit so the rounding constant can never overflow the accumulator.
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned RND    = (1 << SHIFT) >> 1;
  localparam logic signed [SUM_W-1:0] RND_S = SUM_W'(RND);
`ifdef FIR_SAT_EN
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] MIN_S = ~MAX_S;
`endif

  logic signed [DATA_W-1:0] x_q    [TAPS];
  logic signed [DATA_W-1:0] x_d    [TAPS];
  logic signed [COEF_W-1:0] c_q    [TAPS];
  logic signed [COEF_W-1:0] c_d    [TAPS];
  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic signed [PROD_W-1:0] prod_d [TAPS];
  logic                     s1_valid_q, s1_valid_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic                     adv_c;
  logic                     accept_c;
  logic signed [PROD_W-1:0] xe_c, ce_c;
  logic signed [SUM_W-1:0]  sum_c, rnd_sum_c, shifted_c;
  logic [OUT_W-1:0]         res_c;
  logic                     sat_c;

  assign adv_c     = ~out_valid_q | out_ready;
  assign in_ready  = adv_c & ~clear;
  assign accept_c  = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // S2 datapath: sum products, round half up, arithmetic shift, then clip or wrap.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum_c = sum_c + SUM_W'(prod_q[k]);
    end
    rnd_sum_c = sum_c + RND_S;
    shifted_c = rnd_sum_c >>> SHIFT;
`ifdef FIR_SAT_EN
    if (shifted_c > MAX_S) begin
      res_c = OUT_W'(MAX_S);
      sat_c = 1'b1;
    end else if (shifted_c < MIN_S) begin
      res_c = OUT_W'(MIN_S);
      sat_c = 1'b1;
    end else begin
      res_c = OUT_W'(shifted_c);
      sat_c = 1'b0;
    end
`else
    res_c = OUT_W'(shifted_c);
    sat_c = 1'b0;
`endif
  end

  // Next state for delay line, S1 products, S2 output and coefficient bank.
  always_comb begin
    x_d         = x_q;
    c_d         = c_q;
    prod_d      = prod_q;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    xe_c        = '0;
    ce_c        = '0;

    if (accept_c) begin
      x_d[0] = in_data;
      for (int k = 1; k < TAPS; k++) begin
        x_d[k] = x_q[k-1];
      end
    end

    // Products are formed from the freshly shifted line so a sample reaches S1 on its accept edge.
    if (adv_c) begin
      s1_valid_d = accept_c;
      for (int k = 0; k < TAPS; k++) begin
        xe_c      = PROD_W'(x_d[k]);
        ce_c      = PROD_W'(c_q[k]);
        prod_d[k] = xe_c * ce_c;
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = res_c;
        out_sat_d  = sat_c;
      end
    end

    if (clear) begin
      for (int k = 0; k < TAPS; k++) begin
        x_d[k] = '0;
      end
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end

    // Out-of-range addresses match no tap and are dropped.
    for (int k = 0; k < TAPS; k++) begin
      if (coef_we && (coef_addr == AW'(k))) begin
        c_d[k] = coef_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= '0;
        c_q[k]    <= COEF_INIT[k*COEF_W +: COEF_W];
        prod_q[k] <= '0;
      end
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      x_q         <= x_d;
      c_q         <= c_d;
      prod_q      <= prod_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule
